// File: rtl/spi_slave_reg_ctrl_if.sv
// Bus between the SPI register controller, its byte shifters and the config register file.
interface spi_slave_reg_ctrl_if;
  logic       csn;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       en_qpi;
  logic [7:0] dummy_cycles;
  logic [7:0] reg_rd_data;
  logic [1:0] reg_wr_addr;
  logic [7:0] reg_wr_data;
  logic       reg_wr_valid;
  logic [1:0] reg_rd_addr;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       qpi_mode;
  logic       cmd_err;

  modport slave (
    input  csn, rx_data, rx_valid, en_qpi, dummy_cycles, reg_rd_data,
    output reg_wr_addr, reg_wr_data, reg_wr_valid, reg_rd_addr, tx_data, tx_load,
           qpi_mode, cmd_err
  );

  modport master (
    output csn, rx_data, rx_valid, en_qpi, dummy_cycles, reg_rd_data,
    input  reg_wr_addr, reg_wr_data, reg_wr_valid, reg_rd_addr, tx_data, tx_load,
           qpi_mode, cmd_err
  );
endinterface

// File: rtl/spi_slave_reg_ctrl.sv
// SPI slave command decoder: register writes, dummy-delayed register reads, per-frame QPI mode.
// Define SPI_SLAVE_REG_CTRL_AUTOINC_EN for burst writes with a wrapping address increment.
module spi_slave_reg_ctrl (
  input logic                 sclk,
  input logic                 rstn,
  spi_slave_reg_ctrl_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StCmd, StWrData, StDummy, StRdLoad, StDone} state_e;

  state_e     r_state;
  logic [7:0] r_cnt;
  logic [1:0] r_wr_ptr;
  logic [1:0] r_wr_addr;
  logic [7:0] r_wr_data;
  logic       r_wr_valid;
  logic [1:0] r_rd_addr;
  logic [7:0] r_tx_data;
  logic       r_tx_load;
  logic       r_qpi_mode;
  logic       r_cmd_err;

  logic w_is_wr;
  logic w_is_rd;

  assign w_is_wr = (bus.rx_data[7:2] == 6'b000100);
  assign w_is_rd = (bus.rx_data[7:2] == 6'b000101);

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= StIdle;
      r_cnt      <= 8'd0;
      r_wr_ptr   <= 2'd0;
      r_wr_addr  <= 2'd0;
      r_wr_data  <= 8'h00;
      r_wr_valid <= 1'b0;
      r_rd_addr  <= 2'd0;
      r_tx_data  <= 8'h00;
      r_tx_load  <= 1'b0;
      r_qpi_mode <= 1'b0;
      r_cmd_err  <= 1'b0;
    end else begin
      r_wr_valid <= 1'b0;
      r_tx_load  <= 1'b0;
      if (bus.csn) begin
        // Deselect aborts the frame; strobes above are already suppressed.
        r_state <= StIdle;
        r_cnt   <= 8'd0;
      end else begin
        case (r_state)
          StIdle: begin
            r_state    <= StCmd;
            r_qpi_mode <= bus.en_qpi;
            r_cmd_err  <= 1'b0;
          end
          StCmd: begin
            if (bus.rx_valid) begin
              if (w_is_wr) begin
                r_wr_ptr  <= bus.rx_data[1:0];
                r_rd_addr <= bus.rx_data[1:0];
                r_state   <= StWrData;
              end else if (w_is_rd) begin
                r_rd_addr <= bus.rx_data[1:0];
                if (bus.dummy_cycles != 8'd0) begin
                  r_cnt   <= bus.dummy_cycles;
                  r_state <= StDummy;
                end else begin
                  r_state <= StRdLoad;
                end
              end else begin
                r_cmd_err <= 1'b1;
                r_state   <= StDone;
              end
            end
          end
          StWrData: begin
            if (bus.rx_valid) begin
              r_wr_valid <= 1'b1;
              r_wr_data  <= bus.rx_data;
              r_wr_addr  <= r_wr_ptr;
`ifdef SPI_SLAVE_REG_CTRL_AUTOINC_EN
              r_wr_ptr   <= r_wr_ptr + 2'd1;
`else
              r_state    <= StDone;
`endif
            end
          end
          StDummy: begin
            if (r_cnt == 8'd1) begin
              r_cnt   <= 8'd0;
              r_state <= StRdLoad;
            end else begin
              r_cnt <= r_cnt - 8'd1;
            end
          end
          StRdLoad: begin
            r_tx_data <= bus.reg_rd_data;
            r_tx_load <= 1'b1;
            r_state   <= StDone;
          end
          StDone: begin
            r_state <= StDone;
          end
          default: begin
            r_state <= StIdle;
          end
        endcase
      end
    end
  end

  assign bus.reg_wr_addr  = r_wr_addr;
  assign bus.reg_wr_data  = r_wr_data;
  assign bus.reg_wr_valid = r_wr_valid;
  assign bus.reg_rd_addr  = r_rd_addr;
  assign bus.tx_data      = r_tx_data;
  assign bus.tx_load      = r_tx_load;
  assign bus.qpi_mode     = r_qpi_mode;
  assign bus.cmd_err      = r_cmd_err;

endmodule

// File: tb/tb_spi_slave_reg_ctrl.sv
// Directed-vector bench for spi_slave_reg_ctrl; expectations follow the
// SPI_SLAVE_REG_CTRL_AUTOINC_EN setting of the build.
module tb_spi_slave_reg_ctrl;

  logic sclk = 1'b0;
  logic rstn = 1'b0;
  int   total = 0;
  int   bad   = 0;

  spi_slave_reg_ctrl_if bus ();

  spi_slave_reg_ctrl dut (
    .sclk (sclk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 sclk = ~sclk;

  // Register file stub: register n reads back 0xC0 + n.
  assign bus.reg_rd_data = 8'hC0 | {6'd0, bus.reg_rd_addr};

  typedef struct {
    logic       csn;
    logic       rv;
    logic [7:0] rd;
    logic [7:0] dc;
    logic       eq;
    logic       wv;
    logic [1:0] wa;
    logic [7:0] wd;
    logic       tl;
    logic [7:0] td;
    logic       qm;
    logic       ce;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic csn, input logic rv, input logic [7:0] rd,
                              input logic [7:0] dc, input logic eq, input logic wv,
                              input logic [1:0] wa, input logic [7:0] wd, input logic tl,
                              input logic [7:0] td, input logic qm, input logic ce);
    vec_t v;
    v.csn = csn; v.rv = rv; v.rd = rd; v.dc = dc; v.eq = eq;
    v.wv = wv; v.wa = wa; v.wd = wd; v.tl = tl; v.td = td; v.qm = qm; v.ce = ce;
    return v;
  endfunction

  task automatic chk(input string nm, input int row, input logic [7:0] act,
                     input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %h expected %h", nm, row, act, exp);
    end
  endtask

  task automatic chk_outs(input int row, input logic wv, input logic [1:0] wa,
                          input logic [7:0] wd, input logic tl, input logic [7:0] td,
                          input logic qm, input logic ce);
    chk("reg_wr_valid", row, {7'd0, bus.reg_wr_valid}, {7'd0, wv});
    chk("reg_wr_addr", row, {6'd0, bus.reg_wr_addr}, {6'd0, wa});
    chk("reg_wr_data", row, bus.reg_wr_data, wd);
    chk("tx_load", row, {7'd0, bus.tx_load}, {7'd0, tl});
    chk("tx_data", row, bus.tx_data, td);
    chk("qpi_mode", row, {7'd0, bus.qpi_mode}, {7'd0, qm});
    chk("cmd_err", row, {7'd0, bus.cmd_err}, {7'd0, ce});
    chk("wr_load_excl", row, {7'd0, bus.reg_wr_valid & bus.tx_load}, 8'd0);
  endtask

  task automatic drive(input logic csn, input logic rv, input logic [7:0] rd,
                       input logic [7:0] dc, input logic eq);
    bus.csn = csn; bus.rx_valid = rv; bus.rx_data = rd;
    bus.dummy_cycles = dc; bus.en_qpi = eq;
  endtask

  initial begin
    drive(1'b1, 1'b0, 8'h00, 8'd4, 1'b0);
    // Each row: inputs seen by one rising edge, outputs expected just after it.
    // Write frame 0x11,0xA5
    tbl.push_back(mk(1, 0, 8'h00, 4, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 4, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 8'h11, 4, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 4, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 8'hA5, 4, 0, 1, 1, 8'hA5, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 4, 0, 0, 1, 8'hA5, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 0, 8'h00, 4, 1, 0, 1, 8'hA5, 0, 8'h00, 0, 0));
    // Read 0x15 with 4 dummy cycles, qpi captured; dummy_cycles/en_qpi change mid-frame
    tbl.push_back(mk(0, 0, 8'h00, 4, 1, 0, 1, 8'hA5, 0, 8'h00, 1, 0));
    tbl.push_back(mk(0, 1, 8'h15, 4, 0, 0, 1, 8'hA5, 0, 8'h00, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 1, 8'hA5, 0, 8'h00, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 1, 8'hA5, 0, 8'h00, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 1, 8'hA5, 0, 8'h00, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 1, 8'hA5, 0, 8'h00, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 1, 8'hA5, 1, 8'hC1, 1, 0));
    tbl.push_back(mk(0, 1, 8'h11, 1, 0, 0, 1, 8'hA5, 0, 8'hC1, 1, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 1, 8'hA5, 0, 8'hC1, 1, 0));
    // Read 0x16 with no dummy cycles
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 1, 8'hA5, 0, 8'hC1, 0, 0));
    tbl.push_back(mk(0, 1, 8'h16, 0, 0, 0, 1, 8'hA5, 0, 8'hC1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 1, 8'hA5, 1, 8'hC2, 0, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 1, 8'hA5, 0, 8'hC2, 0, 0));
    // Illegal opcode 0x5A, cleared at next frame start
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 1, 8'hA5, 0, 8'hC2, 0, 0));
    tbl.push_back(mk(0, 1, 8'h5A, 0, 0, 0, 1, 8'hA5, 0, 8'hC2, 0, 1));
    tbl.push_back(mk(0, 1, 8'h12, 0, 0, 0, 1, 8'hA5, 0, 8'hC2, 0, 1));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 1, 8'hA5, 0, 8'hC2, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 1, 8'hA5, 0, 8'hC2, 0, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 1, 8'hA5, 0, 8'hC2, 0, 0));
    // Read 0x17, deselect after 2 of 8 dummy cycles; stray bytes while idle
    tbl.push_back(mk(0, 0, 8'h00, 8, 0, 0, 1, 8'hA5, 0, 8'hC2, 0, 0));
    tbl.push_back(mk(0, 1, 8'h17, 8, 0, 0, 1, 8'hA5, 0, 8'hC2, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8, 0, 0, 1, 8'hA5, 0, 8'hC2, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8, 0, 0, 1, 8'hA5, 0, 8'hC2, 0, 0));
    tbl.push_back(mk(1, 0, 8'h00, 8, 0, 0, 1, 8'hA5, 0, 8'hC2, 0, 0));
    tbl.push_back(mk(1, 1, 8'h10, 8, 0, 0, 1, 8'hA5, 0, 8'hC2, 0, 0));
    tbl.push_back(mk(0, 1, 8'h14, 0, 0, 0, 1, 8'hA5, 0, 8'hC2, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 1, 8'hA5, 0, 8'hC2, 0, 0));
    tbl.push_back(mk(0, 1, 8'h14, 0, 0, 0, 1, 8'hA5, 0, 8'hC2, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 1, 8'hA5, 1, 8'hC0, 0, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 1, 8'hA5, 0, 8'hC0, 0, 0));
    // Frame 0x13,0x11,0x22,0x33
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 1, 8'hA5, 0, 8'hC0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h13, 0, 0, 0, 1, 8'hA5, 0, 8'hC0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h11, 0, 0, 1, 3, 8'h11, 0, 8'hC0, 0, 0));
`ifdef SPI_SLAVE_REG_CTRL_AUTOINC_EN
    tbl.push_back(mk(0, 1, 8'h22, 0, 0, 1, 0, 8'h22, 0, 8'hC0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h33, 0, 0, 1, 1, 8'h33, 0, 8'hC0, 0, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 1, 8'h33, 0, 8'hC0, 0, 0));
`else
    tbl.push_back(mk(0, 1, 8'h22, 0, 0, 0, 3, 8'h11, 0, 8'hC0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h33, 0, 0, 0, 3, 8'h11, 0, 8'hC0, 0, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 3, 8'h11, 0, 8'hC0, 0, 0));
`endif

    // Reset values while rstn is held low across clock edges
    repeat (2) @(posedge sclk);
    #1;
    chk_outs(-1, 0, 0, 8'h00, 0, 8'h00, 0, 0);
    @(negedge sclk);
    rstn = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge sclk);
      drive(tbl[i].csn, tbl[i].rv, tbl[i].rd, tbl[i].dc, tbl[i].eq);
      @(posedge sclk);
      #1;
      chk_outs(i, tbl[i].wv, tbl[i].wa, tbl[i].wd, tbl[i].tl, tbl[i].td, tbl[i].qm,
               tbl[i].ce);
    end

    // Asynchronous reset in the middle of WR_DATA, then recovery from IDLE
    @(negedge sclk);
    drive(1'b0, 1'b0, 8'h00, 8'd0, 1'b1);
    @(posedge sclk);
    #1;
    chk("qpi_before_rst", 100, {7'd0, bus.qpi_mode}, 8'd1);
    @(negedge sclk);
    drive(1'b0, 1'b1, 8'h12, 8'd0, 1'b1);
    @(negedge sclk);
    drive(1'b0, 1'b1, 8'h99, 8'd0, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    chk_outs(101, 0, 0, 8'h00, 0, 8'h00, 0, 0);
    @(negedge sclk);
    rstn = 1'b1;
    @(posedge sclk);
    #1;
    chk_outs(102, 0, 0, 8'h00, 0, 8'h00, 1, 0);
    @(negedge sclk);
    drive(1'b0, 1'b1, 8'h12, 8'd0, 1'b1);
    @(negedge sclk);
    drive(1'b0, 1'b1, 8'h66, 8'd0, 1'b1);
    @(posedge sclk);
    #1;
    chk_outs(103, 1, 2, 8'h66, 0, 8'h00, 1, 0);
    @(negedge sclk);
    drive(1'b1, 1'b0, 8'h00, 8'd0, 1'b0);
    @(posedge sclk);
    #1;
    chk_outs(104, 0, 2, 8'h66, 0, 8'h00, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_reg_ctrl.md
SPI_SLAVE_REG_CTRL -- requirements
Module: spi_slave_reg_ctrl

Interface
REQ-001 The block SHALL have: sclk  in  1  SPI clock; all state on rising edge.
REQ-002 The block SHALL have: rstn  in  1  reset, asynchronous, active-low.
REQ-003 The block SHALL have: csn  in  1  chip select, active-low, sampled on sclk.
REQ-004 The block SHALL have: rx_data  in  8  received byte from the shifter; rx_valid  in  1  one-cycle byte strobe.
REQ-005 The block SHALL have: en_qpi  in  1  and dummy_cycles  in  8, both from the config register file.
REQ-006 The block SHALL have: reg_rd_data  in  8  combinational read data from the register file.
REQ-007 The block SHALL have: reg_wr_addr  out  2, reg_wr_data  out  8, reg_wr_valid  out  1  register-file write port.
REQ-008 The block SHALL have: reg_rd_addr  out  2  register-file read address.
REQ-009 The block SHALL have: tx_data  out  8, tx_load  out  1  one-cycle load strobe to the output shifter.
REQ-010 The block SHALL have: qpi_mode  out  1  frame mode for the shifters; cmd_err  out  1  unknown-opcode flag.

Function
REQ-011 Opcodes SHALL be: 0x10-0x13 write register opcode[1:0]; 0x14-0x17 read register opcode[1:0]; all others illegal.
REQ-012 The FSM SHALL have states IDLE, CMD, WR_DATA, DUMMY, RD_LOAD, DONE.
REQ-013 IDLE->CMD on a sclk edge with csn=0; on that edge qpi_mode SHALL capture en_qpi and cmd_err SHALL clear.
REQ-014 qpi_mode SHALL stay constant for the whole frame; a reg0 write takes effect next frame only.
REQ-015 CMD, on rx_valid: write opcode -> WR_DATA (address latched); read opcode -> DUMMY if dummy_cycles!=0, else RD_LOAD; illegal -> DONE with cmd_err=1.
REQ-016 WR_DATA, on rx_valid: reg_wr_valid=1 for exactly one cycle, reg_wr_data=rx_data, reg_wr_addr=latched address, registered (visible the cycle after the strobe).
REQ-017 DUMMY SHALL load a counter with dummy_cycles on entry and decrement per sclk; on the cycle it reaches 1 -> RD_LOAD (exactly dummy_cycles cycles spent in DUMMY).
REQ-018 dummy_cycles SHALL be sampled once at DUMMY entry; later changes do not alter the running count.
REQ-019 RD_LOAD SHALL drive reg_rd_addr=latched address, tx_data=reg_rd_data, tx_load=1 for one cycle, then -> DONE.
REQ-020 reg_rd_addr SHALL hold the latched address from CMD decode until frame end.
REQ-021 DONE SHALL ignore all rx_valid; no writes or loads issued.
REQ-022 csn=1 on any edge SHALL force IDLE next cycle from any state, abort a pending dummy count, and suppress any strobe not yet issued.
REQ-023 rx_valid in IDLE or with csn=1 SHALL be ignored.
REQ-024 reg_wr_valid and tx_load SHALL never assert in the same cycle.
REQ-025 cmd_err SHALL remain set until the next frame start.

Reset
REQ-026 rstn=0 SHALL asynchronously force IDLE, counter=0, reg_wr_valid=0, tx_load=0, reg_wr_addr=0, reg_wr_data=0x00, reg_rd_addr=0, tx_data=0x00, qpi_mode=0, cmd_err=0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame; after release the block waits in IDLE for the next csn=0 sclk edge.

Configuration
REQ-028 Macro SPI_SLAVE_REG_CTRL_AUTOINC_EN defined: WR_DATA stays in WR_DATA after each write, and address increments modulo 4 (3->0), giving burst writes until csn=1.
REQ-029 Macro undefined: WR_DATA -> DONE after the first data byte; further bytes ignored.

Verification
REQ-030 Frame 0x11,0xA5 -> one reg_wr_valid pulse, addr=1, data=0xA5; nothing else.
REQ-031 dummy_cycles=4, frame 0x15 -> 4 cycles in DUMMY, then tx_load=1 with tx_data=reg_rd_data for addr 1; dummy_cycles=0 -> tx_load the cycle after the opcode strobe.
REQ-032 Opcode 0x5A -> cmd_err=1, no write/load; next frame clears cmd_err.
REQ-033 Frame 0x10,0x01 with en_qpi=0 -> qpi_mode stays 0 this frame; next frame with en_qpi=1 -> qpi_mode=1.
REQ-034 csn=1 during DUMMY (2 of 8 cycles) -> no tx_load, IDLE next cycle; rstn=0 mid-WR_DATA -> all outputs at reset values.
REQ-035 Frame 0x13,0x11,0x22,0x33: AUTOINC_EN -> writes addr 3,0,1; without it -> single write addr 3 data 0x11.
